// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order prediction FIFO, mispredict detection, predictor update and flush (stats via BRU_STATS_EN)
module branch_resolve_unit #(
   parameter int DEPTH = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        if_push,
   input  logic [31:0] if_PC,
   input  logic        if_taken,
   input  logic [31:0] if_target,
   output logic        fifo_full,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   output logic        br,
   output logic        br_result,
   output logic [31:0] brPC,
   output logic [31:0] braddr,
   output logic        flush,
   output logic [31:0] redirect_PC,
   output logic        err_underflow,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispred
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;
   logic [31:0] pc_q [DEPTH];
   logic [31:0] tg_q [DEPTH];
   logic [DEPTH-1:0] tk_q;
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic empty, push, pop, e_tk, mis;
   logic [31:0] e_pc, e_tg;
   logic br_q, res_q, flush_q, err_q;
   logic [31:0] brpc_q, braddr_q, redir_q;
   assign empty     = wr_q == rd_q;
   assign fifo_full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign push      = if_push && !fifo_full && !flush_q;
   assign pop       = ex_valid && !flush_q;
   // popped entry (zero prediction on underflow), mispredict and next pointers; a flush empties the FIFO
   always_comb begin
      e_tk = empty ? 1'b0 : tk_q[rd_q[AW-1:0]];
      e_pc = empty ? 32'd0 : pc_q[rd_q[AW-1:0]];
      e_tg = empty ? 32'd0 : tg_q[rd_q[AW-1:0]];
      mis  = ex_is_branch ? (e_tk != ex_taken) || (e_tk && ex_taken && e_tg != ex_target) : e_tk;
      wr_d = flush_q ? '0 : push ? wr_q + PTR_ONE : wr_q;
      rd_d = flush_q ? '0 : (pop && !empty) ? rd_q + PTR_ONE : rd_q;
   end
   // prediction storage; contents are only read while the FIFO is non-empty
   always_ff @(posedge CLK) begin
      if (push) begin
         pc_q[wr_q[AW-1:0]] <= if_PC;
         tg_q[wr_q[AW-1:0]] <= if_target;
         tk_q[wr_q[AW-1:0]] <= if_taken;
      end
   end
   // pointers and registered resolve outputs; br/flush pulse, data outputs hold
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_q     <= '0;
         rd_q     <= '0;
         br_q     <= 1'b0;
         res_q    <= 1'b0;
         flush_q  <= 1'b0;
         err_q    <= 1'b0;
         brpc_q   <= '0;
         braddr_q <= '0;
         redir_q  <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         br_q    <= pop && ex_is_branch;
         flush_q <= pop && mis;
         err_q   <= err_q || (pop && empty);
         if (pop) begin
            res_q    <= ex_taken;
            brpc_q   <= e_pc;
            braddr_q <= ex_target;
            redir_q  <= (ex_is_branch && ex_taken) ? ex_target : e_pc + 32'd4;
         end
      end
   end
   assign br            = br_q;
   assign br_result     = res_q;
   assign brPC          = brpc_q;
   assign braddr        = braddr_q;
   assign flush         = flush_q;
   assign redirect_PC   = redir_q;
   assign err_underflow = err_q;
`ifdef BRU_STATS_EN
   logic [31:0] nbr_q, nmis_q;
   // resolved-branch and mispredict counters, updated alongside the registered outputs
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         nbr_q  <= '0;
         nmis_q <= '0;
      end else begin
         if (pop && ex_is_branch) nbr_q <= nbr_q + 32'd1;
         if (pop && mis) nmis_q <= nmis_q + 32'd1;
      end
   end
   assign stat_branches = nbr_q;
   assign stat_mispred  = nmis_q;
`else
   assign stat_branches = 32'd0;
   assign stat_mispred  = 32'd0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table-driven and sequence checks of branch_resolve_unit
module tb_branch_resolve_unit;
   logic        CLK = 1'b0, nRST = 1'b0;
   logic        if_push = 1'b0, if_taken = 1'b0;
   logic [31:0] if_PC = '0, if_target = '0;
   logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0;
   logic [31:0] ex_target = '0;
   logic        fifo_full, br, br_result, flush, err_underflow;
   logic [31:0] brPC, braddr, redirect_PC, stat_branches, stat_mispred;
   int n_cmp = 0, n_err = 0, exp_b = 0, exp_m = 0;

   typedef struct {
      logic [31:0] pc; logic tk; logic [31:0] tg;
      logic isb; logic xtk; logic [31:0] xtg;
      logic ebr; logic eres; logic efl; logic [31:0] erd;
   } vec_t;
   typedef struct {
      logic br; logic res; logic fl; logic [31:0] pc; logic [31:0] addr; logic [31:0] rd;
   } exp_t;
   vec_t v[7];
   exp_t q[$];
   exp_t e;

   branch_resolve_unit #(.DEPTH(4)) dut (
      .CLK(CLK), .nRST(nRST), .if_push(if_push), .if_PC(if_PC), .if_taken(if_taken),
      .if_target(if_target), .fifo_full(fifo_full), .ex_valid(ex_valid),
      .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
      .br(br), .br_result(br_result), .brPC(brPC), .braddr(braddr), .flush(flush),
      .redirect_PC(redirect_PC), .err_underflow(err_underflow),
      .stat_branches(stat_branches), .stat_mispred(stat_mispred)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      n_cmp++;
      if (a !== x) begin
         n_err++;
         $display("FAIL %s: got %h want %h", n, a, x);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      if_push = 1'b1; if_PC = pc; if_taken = tk; if_target = tg;
      tick();
      if_push = 1'b0;
   endtask

   task automatic pop(input logic isb, input logic tk, input logic [31:0] tg);
      ex_valid = 1'b1; ex_is_branch = isb; ex_taken = tk; ex_target = tg;
      tick();
      ex_valid = 1'b0;
   endtask

   initial begin
      v[0] = '{32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
      v[1] = '{32'h40, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 32'h80};
      v[2] = '{32'h44, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h48};
      v[3] = '{32'h60, 1'b1, 32'h100, 1'b1, 1'b1, 32'h104, 1'b1, 1'b1, 1'b1, 32'h104};
      v[4] = '{32'h50, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h54};
      v[5] = '{32'h70, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0};
      v[6] = '{32'hFFFF_FFFC, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0};
      tick(); tick();
      chk("rst_full", {31'd0, fifo_full}, 32'd0);
      chk("rst_br", {31'd0, br}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_err", {31'd0, err_underflow}, 32'd0);
      chk("rst_brPC", brPC, 32'd0);
      chk("rst_redirect", redirect_PC, 32'd0);
      chk("rst_stat_br", stat_branches, 32'd0);
      nRST = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         push(v[i].pc, v[i].tk, v[i].tg);
         q.push_back('{v[i].ebr, v[i].eres, v[i].efl, v[i].pc, v[i].xtg, v[i].erd});
         pop(v[i].isb, v[i].xtk, v[i].xtg);
         if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb_empty: got 0 entries want 1");
         end else begin
            e = q.pop_front();
            chk($sformatf("v%0d_br", i), {31'd0, br}, {31'd0, e.br});
            chk($sformatf("v%0d_res", i), {31'd0, br_result}, {31'd0, e.res});
            chk($sformatf("v%0d_brPC", i), brPC, e.pc);
            chk($sformatf("v%0d_braddr", i), braddr, e.addr);
            chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, e.fl});
            if (e.fl) chk($sformatf("v%0d_redirect", i), redirect_PC, e.rd);
         end
         exp_b += int'(v[i].ebr);
         exp_m += int'(v[i].efl);
         tick();
         chk($sformatf("v%0d_flush_pulse", i), {31'd0, flush}, 32'd0);
         chk($sformatf("v%0d_br_pulse", i), {31'd0, br}, 32'd0);
      end
      push(32'h300, 1'b1, 32'h400);
      push(32'h304, 1'b0, 32'h0);
      pop(1'b1, 1'b0, 32'h0);
      chk("fl_flush", {31'd0, flush}, 32'd1);
      chk("fl_redirect", redirect_PC, 32'h304);
      push(32'h500, 1'b0, 32'h0);
      push(32'h308, 1'b0, 32'h0);
      pop(1'b1, 1'b0, 32'h0);
      chk("fl_after_brPC", brPC, 32'h308);
      chk("fl_after_flush", {31'd0, flush}, 32'd0);
      exp_b += 2; exp_m += 1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("full_pre%0d", i), {31'd0, fifo_full}, 32'd0);
         push(32'h100 + 32'(4 * i), 1'b0, 32'h0);
      end
      chk("full_set", {31'd0, fifo_full}, 32'd1);
      push(32'h200, 1'b0, 32'h0);
      chk("full_hold", {31'd0, fifo_full}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         pop(1'b1, 1'b0, 32'h0);
         chk($sformatf("full_pop%0d_brPC", i), brPC, 32'h100 + 32'(4 * i));
         chk($sformatf("full_pop%0d_flush", i), {31'd0, flush}, 32'd0);
         chk($sformatf("full_pop%0d_full", i), {31'd0, fifo_full}, 32'd0);
      end
      chk("pre_uf_err", {31'd0, err_underflow}, 32'd0);
      pop(1'b1, 1'b0, 32'h0);
      chk("uf_err", {31'd0, err_underflow}, 32'd1);
      chk("uf_brPC", brPC, 32'h0);
      chk("uf_flush", {31'd0, flush}, 32'd0);
      exp_b += 5;
      tick();
      chk("uf_sticky", {31'd0, err_underflow}, 32'd1);
`ifdef BRU_STATS_EN
      chk("stat_branches", stat_branches, 32'(exp_b));
      chk("stat_mispred", stat_mispred, 32'(exp_m));
`else
      chk("stat_branches_off", stat_branches, 32'd0);
      chk("stat_mispred_off", stat_mispred, 32'd0);
`endif
      for (int i = 0; i < 4; i++) push(32'h600 + 32'(4 * i), 1'b1, 32'h0);
      chk("mid_full", {31'd0, fifo_full}, 32'd1);
      #2 nRST = 1'b0;
      #1;
      chk("mid_full_clr", {31'd0, fifo_full}, 32'd0);
      chk("mid_err_clr", {31'd0, err_underflow}, 32'd0);
      chk("mid_brPC_clr", brPC, 32'd0);
      chk("mid_stat_clr", stat_branches, 32'd0);
      tick();
      nRST = 1'b1;
      tick();
      pop(1'b0, 1'b0, 32'h0);
      chk("mid_uf_err", {31'd0, err_underflow}, 32'd1);
      chk("mid_uf_flush", {31'd0, flush}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
